// File: rtl/lighting_seq.sv
// lighting_seq: multi-channel LED colour sequencer.
// Each channel steps through colour codes 1..2^COLOUR_W-2, manually or automatically.
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-low reset
//   button - per-channel debounced button, bit k controls channel k
//   mode   - 00 manual, 01 auto forward, 10 auto reverse, 11 freeze
//   colour - channel k colour at bits [k*COLOUR_W +: COLOUR_W], registered
//   wrap   - per-channel one-cycle pulse when the sequence wraps, registered
module lighting_seq #(
    parameter int COLOUR_W = 3,
    parameter int N_CH     = 2,
    parameter int TICK_DIV = 4,
    parameter int DIV_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          button,
    input  logic [1:0]               mode,
    output logic [N_CH*COLOUR_W-1:0] colour,
    output logic [N_CH-1:0]          wrap
);

    // Highest legal colour: all ones except the LSB.
    localparam logic [COLOUR_W-1:0] MAXC  = {{(COLOUR_W-1){1'b1}}, 1'b0};
    localparam logic [COLOUR_W-1:0] ONE   = COLOUR_W'(1);
    localparam logic [COLOUR_W-1:0] ONES  = '1;
    localparam logic [DIV_W-1:0]    TLAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0]          cnt;
    logic                      tick;
    logic [N_CH-1:0]           button_q;
    logic [N_CH*COLOUR_W-1:0]  colour_nxt;
    logic [N_CH-1:0]           wrap_nxt;

    assign tick = (cnt == TLAST);

    always_comb begin
        colour_nxt = colour;
        wrap_nxt   = '0;
        for (int k = 0; k < N_CH; k++) begin
            logic [COLOUR_W-1:0] c;
            logic                fwd;
            logic                rev;
            c   = colour[k*COLOUR_W +: COLOUR_W];
            fwd = 1'b0;
            rev = 1'b0;
            case (mode)
                2'b00:   fwd = button[k] & ~button_q[k];
                2'b01:   fwd = tick & button[k];
                2'b10:   rev = tick & button[k];
                default: ;
            endcase
            // Illegal codes recover to 1 in every mode, freeze included.
            if (c == '0 || c == ONES) begin
                colour_nxt[k*COLOUR_W +: COLOUR_W] = ONE;
            end else if (fwd) begin
                if (c == MAXC) begin
                    colour_nxt[k*COLOUR_W +: COLOUR_W] = ONE;
                    wrap_nxt[k] = 1'b1;
                end else begin
                    colour_nxt[k*COLOUR_W +: COLOUR_W] = c + ONE;
                end
            end else if (rev) begin
                if (c == ONE) begin
                    colour_nxt[k*COLOUR_W +: COLOUR_W] = MAXC;
                    wrap_nxt[k] = 1'b1;
                end else begin
                    colour_nxt[k*COLOUR_W +: COLOUR_W] = c - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            button_q <= '0;
            colour   <= '0;
            wrap     <= '0;
        end else begin
            cnt      <= tick ? '0 : cnt + 1'b1;
            button_q <= button;
            colour   <= colour_nxt;
            wrap     <= wrap_nxt;
        end
    end

endmodule

// File: doc/lighting_seq.md
Name: lighting_seq

Overview:
Parametrised, multi-channel successor to the single-channel dynamic LED colour block. Each channel drives an RGB-style colour code that steps through the legal colours 1..2^COLOUR_W-2. The all-zeros and all-ones codes are never produced in steady state. Channels step manually on button edges, or automatically at a prescaled rate, forward or reverse. Sits between the board button/debounce logic and the LED drivers.

Parameters:
COLOUR_W, 3, bits per channel colour code; must be >= 2; legal colours 1..MAXC, where MAXC = 2^COLOUR_W-2
N_CH, 2, number of independent LED channels
TICK_DIV, 4, auto-step period in clk cycles; must be >= 1; 1 = every cycle
DIV_W, 8, prescaler counter width; must satisfy 2^DIV_W >= TICK_DIV

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
button  input  N_CH  per-channel button, already synchronised/debounced; bit k controls channel k
mode  input  2  00 manual, 01 auto forward, 10 auto reverse, 11 freeze; shared by all channels
colour  output  N_CH*COLOUR_W  channel k occupies bits [k*COLOUR_W +: COLOUR_W]; registered
wrap  output  N_CH  one-cycle pulse per channel on sequence wrap; registered

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - colour = 0 for all channels
  - wrap = 0
  - button edge registers = 0
  - prescaler = 0
- Prescaler: free-running 0..TICK_DIV-1, shared by all channels, unaffected by mode. tick=1 in the cycle the count equals TICK_DIV-1; the count then returns to 0.
- Per-channel next-state at each rising edge, in priority order:
  1. Illegal current value (0 or all-ones) -> 1; wrap=0. This applies in every mode, including freeze. The first edge after reset release therefore always gives colour=1.
  2. mode=11 (freeze) -> hold.
  3. mode=00 (manual): step forward when button[k]=1 and button_q[k]=0, where button_q is button registered one cycle earlier. A held button steps exactly once. Otherwise hold.
  4. mode=01: step forward when tick=1 and button[k]=1. Otherwise hold.
  5. mode=10: step reverse when tick=1 and button[k]=1. Otherwise hold.
- Forward step: c -> c+1; MAXC -> 1 with wrap[k]=1.
- Reverse step: c -> c-1; 1 -> MAXC with wrap[k]=1.
- wrap[k] is high for exactly the one cycle in which the wrapped colour value is presented; otherwise 0.
- Latency: an edge-triggering button sampled at rising edge N updates colour at edge N, so it is visible one cycle after button rises.
- button_q updates every cycle in all modes. Switching into manual with the button already held gives no step.
- Mode change mid-sequence: takes effect at the next edge; colour and prescaler are not disturbed.
- Channels are fully independent apart from the shared mode and prescaler. Simultaneous steps on several channels are all honoured in the same cycle.
- Reset asserted mid-operation: outputs clear immediately. After release, operation resumes from colour=1 per rule 1.

Test Plan:
1. Reset/recovery, defaults:
   - rst=0 for 3 cycles -> colour=0, wrap=0 with no clock edge needed.
   - Release rst -> after 1 edge colour=1 on both channels, in every mode.
2. Manual, mode=00:
   - button[0] rises and is held 5 cycles -> colour0 goes 1->2 once only; colour1 stays 1.
   - Release and press again -> colour0=3.
3. Auto forward, mode=01, TICK_DIV=4:
   - button[0] held -> colour0 advances once every 4 cycles: 1,2,3,4,5,6,1.
   - wrap[0]=1 for exactly the cycle showing 1 after 6.
   - colour0 is never 0 or 7 after the first post-reset edge.
4. Auto reverse, mode=10:
   - From colour0=1 with button[0] held -> next step gives 6 with wrap[0]=1, then 5, then 4.
5. Freeze/independence:
   - mode=11, both buttons high 20 cycles -> colours unchanged, wrap=0.
   - Then mode=01 with only button[1] high -> only colour1 moves.
6. Async reset mid-sequence:
   - colour0=4, rst driven low between clock edges -> colour0=0 immediately.
   - Release -> colour0=1 and the prescaler restarts from 0, so the first auto step lands 4 cycles later.
